// File: rtl/mmio_arbiter.sv
// mmio_arbiter: two-requester arbiter onto a shared MMIO bus (IDLE -> ISSUE -> RESP).
// Define MMIO_ARB_RR_EN for round-robin arbitration; the default is fixed priority (requester 0).
module mmio_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              wr0,
    input  logic [DATA_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              wr1,
    input  logic [DATA_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              writeEnable,
    output logic              readEnable,
    output logic [DATA_W-1:0] memAddress,
    output logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] readData
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              win_q, win_d, last_gnt_q, last_gnt_d, wr_q, wr_d;
    logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic              we_q, we_d, re_q, re_d, ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d, wr_data_q, wr_data_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              pick;

`ifdef MMIO_ARB_RR_EN
    assign pick = (req0 && req1) ? ~last_gnt_q : req1;
`else
    assign pick = ~req0;
`endif

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        last_gnt_d = last_gnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        mem_addr_d = mem_addr_q;
        wr_data_d  = wr_data_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    win_d      = pick;
                    last_gnt_d = pick;
                    wr_d       = pick ? wr1 : wr0;
                    addr_d     = pick ? addr1 : addr0;
                    wdata_d    = pick ? wdata1 : wdata0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                we_d       = wr_q;
                re_d       = ~wr_q;
                mem_addr_d = addr_q;
                wr_data_d  = wdata_q;
                state_d    = RESP;
            end
            RESP: begin
                ack0_d   = ~win_q;
                ack1_d   = win_q;
                rdata0_d = (!wr_q && !win_q) ? readData : rdata0_q;
                rdata1_d = (!wr_q && win_q) ? readData : rdata1_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset in ISSUE/RESP drops the transaction: enables and acks are forced low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            win_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            mem_addr_q <= '0;
            wr_data_q  <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            last_gnt_q <= last_gnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            mem_addr_q <= mem_addr_d;
            wr_data_q  <= wr_data_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign writeEnable = we_q;
    assign readEnable  = re_q;
    assign memAddress  = mem_addr_q;
    assign writeData   = wr_data_q;
endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter: directed table, corner sequences and a randomized run against a transaction-level model.
// Follows MMIO_ARB_RR_EN to select round-robin or fixed-priority expectations.
module tb_mmio_arbiter;
`ifdef MMIO_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1;
    logic        req0 = 0, wr0 = 0, req1 = 0, wr1 = 0;
    logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0, readData = 0;
    logic        ack0, ack1, writeEnable, readEnable;
    logic [31:0] rdata0, rdata1, memAddress, writeData;
    int          n_cmp = 0, n_bad = 0;

    mmio_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .writeEnable(writeEnable), .readEnable(readEnable),
        .memAddress(memAddress), .writeData(writeData), .readData(readData)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r0, w0, r1, w1;
        logic [31:0] a0, d0, a1, d1, rd;
        logic        win, ewe;
        logic [31:0] eaddr, edata, er0, er1;
    } vec_t;
    vec_t vt[6];

    // Random-phase model state
    bit          rq[2], rw[2], granted[2];
    logic [31:0] ra[2], rdd[2], exp_rd[2];
    int          g_edge;
    bit          g_win, g_wr, m_last, en, ak, w;
    logic [31:0] g_addr, g_wdata, exp_addr, exp_wdata, rd_drv, rd_edge;

    initial begin
        // win/addr of the tie vectors depend on arbitration mode; lastGnt history: 0,1,0,(RR?1:0),1
        vt[0] = '{1,1,0,0, 32'h100,32'hA5A5,0,0,32'h0, 0,1, 32'h100,32'hA5A5, 32'h0,32'h0};
        vt[1] = '{0,0,1,0, 0,0,32'h200,32'h0,32'hDEADBEEF, 1,0, 32'h200,32'h0, 32'h0,32'hDEADBEEF};
        vt[2] = '{1,0,1,0, 32'h10,32'h1,32'h20,32'h2,32'h11112222, 0,0, 32'h10,32'h1, 32'h11112222,32'hDEADBEEF};
        vt[3] = '{1,1,1,1, 32'h30,32'h33,32'h40,32'h44,32'h0, RR,1, RR ? 32'h40 : 32'h30, RR ? 32'h44 : 32'h33,
                  32'h11112222,32'hDEADBEEF};
        vt[4] = '{0,0,1,1, 0,0,32'h50,32'h55,32'h99999999, 1,1, 32'h50,32'h55, 32'h11112222,32'hDEADBEEF};
        vt[5] = '{1,0,1,0, 32'h60,32'h6,32'h70,32'h7,32'h76543210, 0,0, 32'h60,32'h6, 32'h76543210,32'hDEADBEEF};

        rst = 1; tick; tick;
        check("rst_we", writeEnable, 0); check("rst_re", readEnable, 0);
        check("rst_ack0", ack0, 0); check("rst_ack1", ack1, 0);
        check("rst_addr", memAddress, 0); check("rst_wdata", writeData, 0);
        check("rst_rdata0", rdata0, 0); check("rst_rdata1", rdata1, 0);
        rst = 0; tick;

        for (int i = 0; i < 6; i++) begin
            req0 = vt[i].r0; wr0 = vt[i].w0; addr0 = vt[i].a0; wdata0 = vt[i].d0;
            req1 = vt[i].r1; wr1 = vt[i].w1; addr1 = vt[i].a1; wdata1 = vt[i].d1;
            readData = vt[i].rd;
            tick;
            check($sformatf("v%0d_en_early", i), {writeEnable, readEnable}, 0);
            tick;
            check($sformatf("v%0d_we", i), writeEnable, vt[i].ewe);
            check($sformatf("v%0d_re", i), readEnable, !vt[i].ewe);
            check($sformatf("v%0d_addr", i), memAddress, vt[i].eaddr);
            check($sformatf("v%0d_wdata", i), writeData, vt[i].edata);
            check($sformatf("v%0d_ack_early", i), {ack0, ack1}, 0);
            tick;
            check($sformatf("v%0d_ack0", i), ack0, !vt[i].win);
            check($sformatf("v%0d_ack1", i), ack1, vt[i].win);
            check($sformatf("v%0d_rdata0", i), rdata0, vt[i].er0);
            check($sformatf("v%0d_rdata1", i), rdata1, vt[i].er1);
            check($sformatf("v%0d_en_late", i), {writeEnable, readEnable}, 0);
            check($sformatf("v%0d_addr_hold", i), memAddress, vt[i].eaddr);
            req0 = 0; req1 = 0;
            tick;
        end

        // Contention with both requesters held from reset release
        rst = 1; req0 = 1; wr0 = 0; addr0 = 32'hA0; req1 = 1; wr1 = 0; addr1 = 32'hB0;
        tick; rst = 0;
        for (int j = 1; j <= 12; j++) begin
            tick;
            check($sformatf("cont_ack0_%0d", j), ack0, (j % 3 == 0) && !(RR && ((j / 3 - 1) % 2 == 1)));
            check($sformatf("cont_ack1_%0d", j), ack1, (j % 3 == 0) && RR && ((j / 3 - 1) % 2 == 1));
        end

        // Reset during ISSUE aborts; re-arbitration at the first edge with rst low
        rst = 1; req0 = 0; req1 = 0; tick; rst = 0; tick;
        req0 = 1; wr0 = 1; addr0 = 32'h100; wdata0 = 32'h1234;
        tick;
        rst = 1; tick;
        check("rstmid_we", writeEnable, 0); check("rstmid_re", readEnable, 0);
        check("rstmid_ack", {ack0, ack1}, 0); check("rstmid_addr", memAddress, 0);
        rst = 0; tick; tick;
        check("rstmid_ack_none", {ack0, ack1}, 0);
        check("rstmid_rearb_we", writeEnable, 1);
        check("rstmid_rearb_addr", memAddress, 32'h100);
        tick; check("rstmid_rearb_ack0", ack0, 1);
        req0 = 0; tick;

        // Changing the winner's inputs after the latch has no effect
        req0 = 1; wr0 = 1; addr0 = 32'h100; wdata0 = 32'h5555;
        tick;
        addr0 = 32'h300; wdata0 = 32'h7777; wr0 = 0;
        tick;
        check("latch_addr", memAddress, 32'h100);
        check("latch_wdata", writeData, 32'h5555);
        check("latch_we", writeEnable, 1);
        tick; check("latch_ack0", ack0, 1);
        req0 = 0; tick;

        // Randomized run against a transaction-level model
        rst = 1; tick; rst = 0;
        rq = '{0, 0}; rw = '{0, 0}; granted = '{0, 0}; ra = '{0, 0}; rdd = '{0, 0}; exp_rd = '{0, 0};
        g_edge = -10; g_win = 0; g_wr = 0; g_addr = 0; g_wdata = 0; m_last = 1;
        exp_addr = 0; exp_wdata = 0; rd_drv = 0; readData = 0;
        req0 = 0; req1 = 0;
        for (int k = 1; k <= 3000; k++) begin
            tick;
            rd_edge = rd_drv;
            en = (k == g_edge + 1);
            ak = (k == g_edge + 2);
            if (en) begin exp_addr = g_addr; exp_wdata = g_wdata; end
            if (ak && !g_wr) exp_rd[g_win] = rd_edge;
            check("rnd_we", writeEnable, en && g_wr);
            check("rnd_re", readEnable, en && !g_wr);
            check("rnd_addr", memAddress, exp_addr);
            check("rnd_wdata", writeData, exp_wdata);
            check("rnd_ack0", ack0, ak && !g_win);
            check("rnd_ack1", ack1, ak && g_win);
            check("rnd_rdata0", rdata0, exp_rd[0]);
            check("rnd_rdata1", rdata1, exp_rd[1]);
            if (ak) granted[g_win] = 0;
            for (int i = 0; i < 2; i++) begin
                if (granted[i]) begin
                    rw[i] = 1'($urandom_range(1)); ra[i] = $urandom; rdd[i] = $urandom;
                end else if ($urandom_range(3) == 0) begin
                    rq[i] = 1'($urandom_range(1)); rw[i] = 1'($urandom_range(1));
                    ra[i] = $urandom; rdd[i] = $urandom;
                end
            end
            rd_drv = $urandom;
            req0 = rq[0]; wr0 = rw[0]; addr0 = ra[0]; wdata0 = rdd[0];
            req1 = rq[1]; wr1 = rw[1]; addr1 = ra[1]; wdata1 = rdd[1];
            readData = rd_drv;
            if (k + 1 >= g_edge + 3 && (rq[0] || rq[1])) begin
                w = (rq[0] && rq[1]) ? (RR ? !m_last : 1'b0) : rq[1];
                m_last = w; g_edge = k + 1; g_win = w; g_wr = rw[w];
                g_addr = ra[w]; g_wdata = rdd[w]; granted[w] = 1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mmio_arbiter.md
MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 The block SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-002 Parameter: DATA_W, 32, width of address, write-data and read-data buses.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- req0  in  1  requester 0 transaction request
- wr0  in  1  requester 0 write (1) / read (0)
- addr0  in  DATA_W  requester 0 address
- wdata0  in  DATA_W  requester 0 write data
- ack0  out  1  requester 0 completion strobe
- rdata0  out  DATA_W  requester 0 read data, valid with ack0
- req1, wr1, addr1, wdata1, ack1, rdata1  same as above, for requester 1
- writeEnable  out  1  shared peripheral bus write strobe
- readEnable  out  1  shared peripheral bus read strobe
- memAddress  out  DATA_W  shared bus address
- writeData  out  DATA_W  shared bus write data
- readData  in  DATA_W  shared bus read data, registered by peripheral

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE and RESP, encoded in 2 bits; the unused encoding SHALL go to IDLE.
REQ-005 IDLE: if req0 or req1 is high, the arbiter SHALL select a winner, register its wr/addr/wdata, record the winner, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-006 ISSUE: for exactly one cycle, the arbiter SHALL drive memAddress/writeData from the registered values, with writeEnable=wr and readEnable=~wr; the FSM SHALL then go to RESP.
REQ-007 RESP: the arbiter SHALL capture readData into the winner's rdata register (reads only), pulse the winner's ack for one cycle, and go to IDLE.
- Latency: req sampled at edge N, enable at N+1, ack at N+2.
- Maximum rate: one transaction per 3 cycles.
REQ-008 writeEnable and readEnable SHALL be 0 in every state except ISSUE, and SHALL never both be 1.
REQ-009 memAddress and writeData SHALL hold their last registered values outside ISSUE.
REQ-010 The non-winner's ack SHALL stay 0; its rdata SHALL keep its previous value.
REQ-011 After a write, rdata of the winner SHALL be unchanged.
REQ-012 Requesters SHALL hold req and their signals until ack; changes to a requester's signals after the winner is latched SHALL NOT affect the transaction in flight.
REQ-013 If a requester's req is still high in the cycle after its ack, that SHALL count as a new request at the next IDLE.
REQ-014 A req dropped before arbitration SHALL be ignored without an ack.
REQ-015 lastGnt (1 bit) SHALL record the winner of each arbitration.

Reset
REQ-016 While rst is high at a clk edge, the block SHALL set:
- state = IDLE; ack0 = ack1 = 0; writeEnable = readEnable = 0
- memAddress = writeData = 0; rdata0 = rdata1 = 0; lastGnt = 1
REQ-017 Reset asserted in ISSUE or RESP SHALL abort the transaction: no ack is issued and no enable appears in the next cycle.
REQ-018 After reset is released, the first arbitration SHALL occur at the first edge where rst is low.

Configuration
REQ-019 With macro MMIO_ARB_RR_EN defined, arbitration SHALL be round-robin: if both req are high, the winner is ~lastGnt; a single requester always wins.
REQ-020 Without MMIO_ARB_RR_EN, arbitration SHALL be fixed priority (requester 0 wins ties); lastGnt is still updated but not used.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single write: req0=1, wr0=1, addr0=0x00000100, wdata0=0x0000A5A5 -> cycle+1: writeEnable=1, memAddress=0x100, writeData=0xA5A5; cycle+2: ack0=1.
- Single read: req1=1, wr1=0, addr1=0x200, readData=0xDEADBEEF -> cycle+1: readEnable=1; cycle+2: ack1=1, rdata1=0xDEADBEEF, rdata0 unchanged.
- Contention, RR enabled: req0 and req1 held continuously after reset -> grant order 0,1,0,1; one ack per 3 cycles, alternating.
- Contention, RR disabled: req0 and req1 held -> requester 0 wins every arbitration; ack1 is never asserted while req0 is held.
- Reset mid-operation: rst=1 in the ISSUE cycle -> next cycle: writeEnable=readEnable=0, ack0=ack1=0, state IDLE.
- Input change after latch: addr0 changed from 0x100 to 0x300 in the ISSUE cycle -> memAddress stays 0x100.
